// File: rtl/led_irq_mux_if.sv
// rtl/led_irq_mux_if.sv - LED/interrupt aggregation bus between the static region and led_irq_mux
interface led_irq_mux_if #(
  parameter int NUM_CH = 3,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 8
);
  logic                    dfx_active;
  logic [NUM_CH-1:0]       led_i;
  logic [NUM_CH-1:0]       led_int_i;
  logic                    led_default_i;
  logic [SEL_W-1:0]        led_sel_i;
  logic [NUM_CH-1:0]       int_en_i;
  logic [NUM_CH-1:0]       int_clr_i;
  logic                    cnt_clr_i;
  logic                    led_o;
  logic [NUM_CH-1:0]       int_vec_o;
  logic                    irq_o;
  logic [NUM_CH-1:0]       pending_o;
  logic                    decoupled_o;
  logic [NUM_CH*CNT_W-1:0] ev_cnt_o;

  modport master (
    output dfx_active, led_i, led_int_i, led_default_i, led_sel_i,
    output int_en_i, int_clr_i, cnt_clr_i,
    input  led_o, int_vec_o, irq_o, pending_o, decoupled_o, ev_cnt_o
  );

  modport slave (
    input  dfx_active, led_i, led_int_i, led_default_i, led_sel_i,
    input  int_en_i, int_clr_i, cnt_clr_i,
    output led_o, int_vec_o, irq_o, pending_o, decoupled_o, ev_cnt_o
  );
endinterface

// File: rtl/led_irq_mux.sv
// rtl/led_irq_mux.sv - DFX-aware RP LED select, sticky masked interrupt vector and event counters
module led_irq_mux #(
  parameter int              NUM_CH    = 3,
  parameter int              SEL_W     = 2,
  parameter int              CNT_W     = 8,
  parameter int              HOLDOFF   = 16,
  parameter logic [NUM_CH-1:0] EDGE_MODE = '1
) (
  input  logic         clk100,
  input  logic         rst,
  led_irq_mux_if.slave bus
);
  localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  typedef enum logic [1:0] {RUN = 2'd0, DECOUPLE = 2'd1, SETTLE = 2'd2} state_t;

  state_t            state, state_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic              decoupled;
  logic              run;
  logic [NUM_CH-1:0] led_r, int_r, int_q;
  logic [NUM_CH-1:0] rise, ev_acc, pending;
  logic              led_q, sel_valid, sel_led;

  always_ff @(posedge clk100) begin
    if (rst) begin
      state     <= RUN;
      hold_cnt  <= '0;
      decoupled <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_nxt;
      decoupled <= (state_nxt != RUN);
    end
  end

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    unique case (state)
      RUN: begin
        if (bus.dfx_active) state_nxt = DECOUPLE;
      end
      DECOUPLE: begin
        if (!bus.dfx_active) begin
          state_nxt = SETTLE;
          hold_nxt  = HOLD_W'(HOLDOFF - 1);
        end
      end
      SETTLE: begin
        if (bus.dfx_active) state_nxt = DECOUPLE;
        else if (hold_cnt == '0) state_nxt = RUN;
        else hold_nxt = hold_cnt - HOLD_W'(1);
      end
      default: state_nxt = RUN;
    endcase
  end

  assign run    = (state == RUN);
  // int_q tracks in every state so a level held across reconfiguration is not seen as an edge
  assign rise   = int_r & ~int_q;
  assign ev_acc = {NUM_CH{run}} & ((rise & EDGE_MODE) | (int_r & ~EDGE_MODE));

  always_comb begin
    sel_valid = 1'b0;
    sel_led   = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (int'(bus.led_sel_i) == k) begin
        sel_valid = 1'b1;
        sel_led   = led_r[k];
      end
    end
  end

  always_ff @(posedge clk100) begin
    if (rst) begin
      led_r   <= '0;
      int_r   <= '0;
      int_q   <= '0;
      pending <= '0;
      led_q   <= 1'b0;
    end else begin
      led_r   <= bus.led_i;
      int_r   <= bus.led_int_i;
      int_q   <= int_r;
      pending <= (pending & ~bus.int_clr_i) | ev_acc;
      // RP-sourced LED freezes while decoupled; the static default is always live
      if (!sel_valid) led_q <= bus.led_default_i;
      else if (run)   led_q <= sel_led;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_cnt
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk100) begin
      if (rst || bus.cnt_clr_i) cnt <= '0;
      else if (run && rise[k] && (cnt != {CNT_W{1'b1}})) cnt <= cnt + CNT_W'(1);
    end
    assign bus.ev_cnt_o[k*CNT_W +: CNT_W] = cnt;
  end

  assign bus.led_o       = led_q;
  assign bus.pending_o   = pending;
  assign bus.int_vec_o   = pending & bus.int_en_i;
  assign bus.irq_o       = |(pending & bus.int_en_i);
  assign bus.decoupled_o = decoupled;
endmodule

// File: tb/tb_led_irq_mux.sv
// tb/tb_led_irq_mux.sv - scoreboard bench for led_irq_mux (edge/level capture, DFX decouple, LED select)
module tb_led_irq_mux;
  typedef enum int {F_PEND, F_VEC, F_IRQ, F_LED, F_DEC, F_CNT0, F_CNT1, F_CNT2} fld_t;
  typedef struct {
    int          cyc;
    int          dut;
    fld_t        f;
    logic [23:0] val;
    string       name;
  } exp_t;

  logic clk100 = 1'b0;
  logic rst;
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];
  logic [23:0] act;
  logic [7:0]  pat;

  led_irq_mux_if #(.NUM_CH(3), .SEL_W(2), .CNT_W(8)) bus_a ();
  led_irq_mux_if #(.NUM_CH(3), .SEL_W(2), .CNT_W(2)) bus_b ();

  led_irq_mux #(.NUM_CH(3), .SEL_W(2), .CNT_W(8), .HOLDOFF(16), .EDGE_MODE(3'b111))
    dut_a (.clk100(clk100), .rst(rst), .bus(bus_a));
  led_irq_mux #(.NUM_CH(3), .SEL_W(2), .CNT_W(2), .HOLDOFF(16), .EDGE_MODE(3'b000))
    dut_b (.clk100(clk100), .rst(rst), .bus(bus_b));

  always #5 clk100 = ~clk100;
  always @(posedge clk100) cyc <= cyc + 1;

  function automatic logic [23:0] get_act(input int d, input fld_t f);
    logic [2:0]  pend, vec;
    logic        irq, led, dec;
    logic [23:0] cnt;
    int          w, ch;
    if (d == 0) begin
      pend = bus_a.pending_o; vec = bus_a.int_vec_o; irq = bus_a.irq_o;
      led = bus_a.led_o; dec = bus_a.decoupled_o; cnt = bus_a.ev_cnt_o; w = 8;
    end else begin
      pend = bus_b.pending_o; vec = bus_b.int_vec_o; irq = bus_b.irq_o;
      led = bus_b.led_o; dec = bus_b.decoupled_o; cnt = 24'(bus_b.ev_cnt_o); w = 2;
    end
    case (f)
      F_PEND:  return 24'(pend);
      F_VEC:   return 24'(vec);
      F_IRQ:   return 24'(irq);
      F_LED:   return 24'(led);
      F_DEC:   return 24'(dec);
      default: begin
        ch = int'(f) - int'(F_CNT0);
        return (cnt >> (ch * w)) & ((24'd1 << w) - 24'd1);
      end
    endcase
  endfunction

  task automatic chk(input int k, input int d, input fld_t f, input logic [23:0] v, input string n);
    exp_t e;
    e.cyc = cyc + k; e.dut = d; e.f = f; e.val = v; e.name = n;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk100);
      #1;
    end
  endtask

  always @(negedge clk100) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        act = get_act(sb[i].dut, sb[i].f);
        n_vec++;
        if (sb[i].cyc < cyc) begin
          n_err++;
          $display("FAIL %s: check for cycle %0d not reached (now %0d)", sb[i].name, sb[i].cyc, cyc);
        end else if (act !== sb[i].val) begin
          n_err++;
          $display("FAIL %s (dut %0d, cycle %0d): got 'h%0h, expected 'h%0h",
                   sb[i].name, sb[i].dut, cyc, act, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus_a.dfx_active = 0; bus_a.led_i = 0; bus_a.led_int_i = 0; bus_a.led_default_i = 0;
    bus_a.led_sel_i = 0; bus_a.int_en_i = 0; bus_a.int_clr_i = 0; bus_a.cnt_clr_i = 0;
    bus_b.dfx_active = 0; bus_b.led_i = 0; bus_b.led_int_i = 0; bus_b.led_default_i = 0;
    bus_b.led_sel_i = 0; bus_b.int_en_i = 0; bus_b.int_clr_i = 0; bus_b.cnt_clr_i = 0;
    tick(2);
    for (int d = 0; d < 2; d++) begin
      chk(0, d, F_LED, 0, "rst_led");
      chk(0, d, F_PEND, 0, "rst_pend");
      chk(0, d, F_DEC, 0, "rst_dec");
      chk(0, d, F_CNT0, 0, "rst_cnt0");
      chk(0, d, F_IRQ, 0, "rst_irq");
    end
    rst = 1'b0;
    tick(2);

    bus_a.int_en_i = 3'b111; tick(1);
    bus_a.led_int_i = 3'b010;
    chk(1, 0, F_PEND, 3'b000, "edge_pend_n1");
    chk(2, 0, F_PEND, 3'b010, "edge_pend_n2");
    chk(2, 0, F_VEC, 3'b010, "edge_vec");
    chk(2, 0, F_IRQ, 1, "edge_irq");
    tick(5); bus_a.led_int_i = 3'b000; tick(2);
    chk(0, 0, F_CNT1, 1, "edge_cnt1_once");
    chk(0, 0, F_PEND, 3'b010, "edge_pend_sticky");
    bus_a.int_clr_i = 3'b010; tick(1); bus_a.int_clr_i = 3'b000;
    chk(0, 0, F_PEND, 3'b000, "edge_clr_pend");
    chk(0, 0, F_IRQ, 0, "edge_clr_irq");

    bus_a.int_en_i = 3'b000; bus_a.led_int_i = 3'b001;
    chk(2, 0, F_PEND, 3'b001, "mask_pend");
    chk(2, 0, F_VEC, 3'b000, "mask_vec");
    chk(2, 0, F_IRQ, 0, "mask_irq");
    tick(3); bus_a.led_int_i = 3'b000; bus_a.int_en_i = 3'b001;
    chk(0, 0, F_IRQ, 1, "unmask_irq_same_cycle");
    chk(0, 0, F_VEC, 3'b001, "unmask_vec");
    tick(2);
    bus_a.led_int_i = 3'b001; tick(1);
    bus_a.int_clr_i = 3'b001; tick(1);
    bus_a.int_clr_i = 3'b000; bus_a.led_int_i = 3'b000;
    chk(0, 0, F_PEND, 3'b001, "set_beats_clr");
    chk(0, 0, F_CNT0, 2, "set_clr_cnt0");
    tick(1); bus_a.int_clr_i = 3'b001; tick(1); bus_a.int_clr_i = 3'b000;
    chk(0, 0, F_PEND, 3'b000, "mask_final_clr");

    pat = 8'b1011_0010;
    bus_a.led_sel_i = 2'd3;
    for (int i = 0; i < 6; i++) begin
      bus_a.led_default_i = pat[i];
      chk(1, 0, F_LED, pat[i], "led_default_1cyc");
      tick(1);
    end
    bus_a.led_sel_i = 2'd0; bus_a.led_i = 3'b000; tick(3);
    for (int i = 0; i < 6; i++) begin
      bus_a.led_i = {~pat[i], ~pat[i], pat[i]};
      chk(2, 0, F_LED, pat[i], "led_ch0_2cyc");
      tick(1);
    end
    tick(2);

    bus_a.led_sel_i = 2'd1; bus_a.led_i = 3'b010; tick(3);
    chk(0, 0, F_LED, 1, "dfx_pre_led");
    bus_a.dfx_active = 1'b1;
    chk(1, 0, F_DEC, 1, "dfx_dec_rise");
    tick(1);
    for (int i = 0; i < 20; i++) begin
      bus_a.led_i     = i[0] ? 3'b111 : 3'b000;
      bus_a.led_int_i = i[0] ? 3'b111 : 3'b000;
      if (i < 10) begin
        chk(0, 0, F_LED, 1, "dfx_led_frozen");
      end else begin
        bus_a.led_sel_i = 2'd3;
        bus_a.led_default_i = i[1];
        chk(1, 0, F_LED, i[1], "dfx_led_default_live");
      end
      chk(0, 0, F_DEC, 1, "dfx_dec_high");
      chk(0, 0, F_PEND, 3'b000, "dfx_no_pend");
      tick(1);
    end
    bus_a.led_int_i = 3'b100; tick(2);
    bus_a.dfx_active = 1'b0;
    chk(16, 0, F_DEC, 1, "settle_dec_hold");
    chk(17, 0, F_DEC, 0, "settle_dec_fall");
    tick(25);
    chk(0, 0, F_PEND, 3'b000, "return_no_spurious");
    chk(0, 0, F_CNT2, 0, "return_cnt2");
    chk(0, 0, F_CNT1, 1, "return_cnt1");
    chk(0, 0, F_CNT0, 2, "return_cnt0");

    bus_a.led_int_i = 3'b000; bus_a.dfx_active = 1'b1; tick(3);
    bus_a.dfx_active = 1'b0; tick(6);
    bus_a.dfx_active = 1'b1; tick(3);
    bus_a.dfx_active = 1'b0;
    chk(16, 0, F_DEC, 1, "reenter_hold");
    chk(17, 0, F_DEC, 0, "reenter_fall");
    tick(20);

    bus_b.int_en_i = 3'b111; bus_b.led_int_i = 3'b100;
    chk(2, 1, F_PEND, 3'b100, "lvl_set");
    chk(2, 1, F_IRQ, 1, "lvl_irq");
    tick(3); bus_b.int_clr_i = 3'b100; tick(1); bus_b.int_clr_i = 3'b000;
    chk(0, 1, F_PEND, 3'b100, "lvl_clr_blocked");
    bus_b.led_int_i = 3'b000; tick(2);
    bus_b.int_clr_i = 3'b100; tick(1); bus_b.int_clr_i = 3'b000;
    chk(0, 1, F_PEND, 3'b000, "lvl_clr");
    chk(0, 1, F_CNT2, 1, "lvl_cnt2");

    for (int i = 0; i < 5; i++) begin
      bus_b.led_int_i = 3'b001; tick(1);
      bus_b.led_int_i = 3'b000; tick(1);
    end
    chk(0, 1, F_CNT0, 3, "sat_cnt0");
    tick(1);
    for (int r = 0; r < 2; r++) begin
      bus_b.led_int_i = 3'b001; tick(1);
      bus_b.cnt_clr_i = 1'b1; tick(1);
      bus_b.cnt_clr_i = 1'b0; bus_b.led_int_i = 3'b000;
      chk(0, 1, F_CNT0, 0, "clr_beats_inc");
      chk(0, 1, F_CNT2, 0, "clr_all");
      tick(2);
    end

    bus_b.led_int_i = 3'b010; tick(1);
    bus_b.led_int_i = 3'b000; bus_b.led_sel_i = 2'd3; bus_b.led_default_i = 1'b1; tick(2);
    chk(0, 1, F_CNT1, 1, "pre_rst_cnt1");
    chk(0, 1, F_LED, 1, "pre_rst_led");
    chk(0, 1, F_PEND, 3'b011, "pre_rst_pend");
    bus_b.dfx_active = 1'b1; bus_a.dfx_active = 1'b1; tick(3);
    bus_b.dfx_active = 1'b0; tick(4);
    chk(0, 1, F_DEC, 1, "pre_rst_settle");
    rst = 1'b1; tick(1); rst = 1'b0;
    chk(0, 1, F_DEC, 0, "rst_settle_dec");
    chk(0, 1, F_PEND, 3'b000, "rst_settle_pend");
    chk(0, 1, F_LED, 0, "rst_settle_led");
    chk(0, 1, F_CNT1, 0, "rst_settle_cnt1");
    chk(0, 0, F_DEC, 0, "rst_a_dec");
    chk(0, 0, F_LED, 0, "rst_a_led");
    chk(0, 0, F_CNT0, 0, "rst_a_cnt0");
    chk(1, 0, F_DEC, 1, "rst_a_redecouple");
    chk(1, 1, F_DEC, 0, "rst_b_stays_run");
    tick(3);

    for (int g = 0; g < 100 && sb.size() > 0; g++) tick(1);
    if (sb.size() > 0) begin
      $display("FAIL drain: %0d checks never reached", sb.size());
      n_vec += sb.size();
      n_err += sb.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
